// File: rtl/disp_pkg.sv
// Shared display definitions for the seven-segment display blocks.
//   scan_state_t : scan controller state (dead time / digit shown)
//   SEG_OFF      : all segments dark (active-low)
//   AN_OFF       : all anodes disabled (active-low)
//   SEG_D0..D9   : active-low {g,f,e,d,c,b,a} patterns for BCD 0-9
package disp_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [6:0] SEG_D0 = 7'h40;
    localparam logic [6:0] SEG_D1 = 7'h79;
    localparam logic [6:0] SEG_D2 = 7'h24;
    localparam logic [6:0] SEG_D3 = 7'h30;
    localparam logic [6:0] SEG_D4 = 7'h19;
    localparam logic [6:0] SEG_D5 = 7'h12;
    localparam logic [6:0] SEG_D6 = 7'h02;
    localparam logic [6:0] SEG_D7 = 7'h78;
    localparam logic [6:0] SEG_D8 = 7'h00;
    localparam logic [6:0] SEG_D9 = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
//   i_digit : 4-bit digit value; 0-9 decode, 10-15 give all segments dark
//   o_seg   : segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'd0:    o_seg = SEG_D0;
            4'd1:    o_seg = SEG_D1;
            4'd2:    o_seg = SEG_D2;
            4'd3:    o_seg = SEG_D3;
            4'd4:    o_seg = SEG_D4;
            4'd5:    o_seg = SEG_D5;
            4'd6:    o_seg = SEG_D6;
            4'd7:    o_seg = SEG_D7;
            4'd8:    o_seg = SEG_D8;
            4'd9:    o_seg = SEG_D9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit seven-segment scan controller for the 12-hour clock display.
// Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES of dead time (all
// anodes off, lets the external quad mux settle on the new select) followed
// by SHOW, where the digit latched at the end of BLANK is displayed.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   en         : scan enable; low forces the display dark and holds S
//   Y          : digit from the quad mux for the current S
//   lz_blank   : suppress digit 3 when it is zero (hour-tens leading zero)
//   dp_mask    : decimal point request per digit
//   S          : digit select to the quad mux
//   AN         : anode enables, active-low
//   SEG        : segments {g,f,e,d,c,b,a}, active-low
//   DP         : decimal point, active-low
//   frame_tick : one-cycle pulse when S wraps 3->0
module digit_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] Y,
    input  logic       lz_blank,
    input  logic [3:0] dp_mask,
    output logic [1:0] S,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       frame_tick
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("digit_scan_ctrl: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV");
    end

    scan_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_s, w_s_nxt;
    logic [3:0]    r_an, w_an_nxt;
    logic [6:0]    r_seg, w_seg_nxt;
    logic          r_dp, w_dp_nxt;
    logic          r_tick, w_tick_nxt;
    logic [6:0]    w_seg_dec;
    logic          w_suppress;

    seg7_decode u_dec (
        .i_digit (Y),
        .o_seg   (w_seg_dec)
    );

    assign w_suppress = lz_blank && (r_s == 2'd3) && (Y == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_s     <= '0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s     <= w_s_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_s_nxt     = r_s;
        w_an_nxt    = r_an;
        w_seg_nxt   = r_seg;
        w_dp_nxt    = r_dp;
        w_tick_nxt  = 1'b0;

        if (!en) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_an_nxt    = AN_OFF;
            w_seg_nxt   = SEG_OFF;
            w_dp_nxt    = 1'b1;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    w_an_nxt  = AN_OFF;
                    w_seg_nxt = SEG_OFF;
                    w_dp_nxt  = 1'b1;
                    // Y is sampled only here, after the full dead time.
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = '0;
                        w_seg_nxt   = w_seg_dec;
                        w_dp_nxt    = w_suppress ? 1'b1 : ~dp_mask[r_s];
                        w_an_nxt    = w_suppress ? AN_OFF : ~(4'b0001 << r_s);
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        w_an_nxt    = AN_OFF;
                        w_seg_nxt   = SEG_OFF;
                        w_dp_nxt    = 1'b1;
                        w_s_nxt     = r_s + 2'd1;
                        w_tick_nxt  = (r_s == 2'd3);
                    end
                end
                default: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign S          = r_s;
    assign AN         = r_an;
    assign SEG        = r_seg;
    assign DP         = r_dp;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] Y;
    logic       lz_blank;
    logic [3:0] dp_mask;
    logic [1:0] S;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       frame_tick;

    int n_checks = 0;
    int n_fails  = 0;

    digit_scan_ctrl #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .Y          (Y),
        .lz_blank   (lz_blank),
        .dp_mask    (dp_mask),
        .S          (S),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Continuous safety checks: at most one anode low, anodes off when S moves.
    logic [1:0] prev_s = 2'd0;
    always @(negedge clk) begin
        n_checks++;
        if ($countones(~AN) > 1) begin
            n_fails++;
            $display("FAIL an_onehot at %0t: got %b expected at most one low bit", $time, AN);
        end
        if (S != prev_s) begin
            n_checks++;
            if (AN !== 4'b1111) begin
                n_fails++;
                $display("FAIL an_off_on_s_change at %0t: got %b expected 1111", $time, AN);
            end
        end
        prev_s = S;
    end

    typedef struct {
        logic [3:0] y;
        logic       lz;
        logic [3:0] dpm;
        logic [1:0] s;
        logic [3:0] an;
        logic [6:0] seg;
        logic       chk_seg;
        logic       dp;
        logic       tick;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // One record per digit slot, starting at S=1 after the hand-checked first slot.
        tbl[0]  = '{4'd1, 1'b0, 4'b0000, 2'd1, 4'b1101, 7'h79, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4'd2, 1'b0, 4'b0100, 2'd2, 4'b1011, 7'h24, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'd0, 1'b1, 4'b1000, 2'd3, 4'b1111, 7'h40, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{4'd8, 1'b0, 4'b0001, 2'd0, 4'b1110, 7'h00, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'hB, 1'b0, 4'b0010, 2'd1, 4'b1101, 7'h7F, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'd9, 1'b0, 4'b0000, 2'd2, 4'b1011, 7'h10, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{4'd0, 1'b0, 4'b0000, 2'd3, 4'b0111, 7'h40, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{4'd3, 1'b1, 4'b0000, 2'd0, 4'b1110, 7'h30, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{4'd7, 1'b1, 4'b0000, 2'd1, 4'b1101, 7'h78, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{4'd6, 1'b0, 4'b0000, 2'd2, 4'b1011, 7'h02, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{4'd4, 1'b1, 4'b0000, 2'd3, 4'b0111, 7'h19, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{4'hF, 1'b0, 4'b0001, 2'd0, 4'b1110, 7'h7F, 1'b1, 1'b0, 1'b0};

        reset    = 1'b1;
        en       = 1'b1;
        Y        = 4'd5;
        lz_blank = 1'b0;
        dp_mask  = 4'b0000;

        // Release reset between edges: this is cycle 0.
        #12 reset = 1'b0;
        chk("rst_S", S, 2'd0);
        chk("rst_AN", AN, 4'b1111);
        chk("rst_SEG", SEG, 7'h7F);
        chk("rst_DP", DP, 1'b1);
        chk("rst_tick", frame_tick, 1'b0);

        step(1);
        chk("c1_AN_dark", AN, 4'b1111);
        step(1);
        chk("c2_AN", AN, 4'b1110);
        chk("c2_SEG", SEG, 7'h12);
        chk("c2_DP", DP, 1'b1);
        step(5);
        chk("c7_AN_hold", AN, 4'b1110);
        step(1);
        chk("c8_AN", AN, 4'b1111);
        chk("c8_S", S, 2'd1);

        // Free-running slots; Y is disturbed during SHOW to confirm it is not re-sampled.
        for (int i = 0; i < 12; i++) begin
            Y        = tbl[i].y;
            lz_blank = tbl[i].lz;
            dp_mask  = tbl[i].dpm;
            step(1);
            chk("blank_AN", AN, 4'b1111);
            chk("blank_tick", frame_tick, 1'b0);
            step(1);
            chk("show_S", S, tbl[i].s);
            chk("show_AN", AN, tbl[i].an);
            if (tbl[i].chk_seg) chk("show_SEG", SEG, tbl[i].seg);
            chk("show_DP", DP, tbl[i].dp);
            Y = ~tbl[i].y;
            step(5);
            chk("show_AN_end", AN, tbl[i].an);
            if (tbl[i].chk_seg) chk("show_SEG_yhold", SEG, tbl[i].seg);
            step(1);
            chk("end_AN", AN, 4'b1111);
            chk("end_S", S, 2'(tbl[i].s + 2'd1));
            chk("end_tick", frame_tick, tbl[i].tick);
        end

        // Now at start of digit 1 slot. Run to digit 2 SHOW, then drop en mid-SHOW.
        Y        = 4'd2;
        lz_blank = 1'b0;
        dp_mask  = 4'b0000;
        step(8);
        chk("en_pre_S", S, 2'd2);
        step(2);
        chk("en_pre_AN", AN, 4'b1011);
        step(2);
        en = 1'b0;
        step(1);
        chk("en_off_AN", AN, 4'b1111);
        chk("en_off_S", S, 2'd2);
        chk("en_off_SEG", SEG, 7'h7F);
        chk("en_off_DP", DP, 1'b1);
        step(3);
        chk("en_off_hold_S", S, 2'd2);
        chk("en_off_hold_AN", AN, 4'b1111);
        en = 1'b1;
        step(1);
        chk("en_on_dark1", AN, 4'b1111);
        step(1);
        chk("en_on_AN", AN, 4'b1011);
        chk("en_on_S", S, 2'd2);
        chk("en_on_SEG", SEG, 7'h24);

        // Asynchronous reset in the middle of SHOW.
        step(2);
        #2 reset = 1'b1;
        #1;
        chk("arst_AN", AN, 4'b1111);
        chk("arst_S", S, 2'd0);
        chk("arst_SEG", SEG, 7'h7F);
        chk("arst_DP", DP, 1'b1);
        Y = 4'd1;
        step(1);
        #2 reset = 1'b0;
        step(2);
        chk("restart_AN", AN, 4'b1110);
        chk("restart_SEG", SEG, 7'h79);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
